// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state encoding, opcodes and ALU codes for the multicycle controller
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_FETCH2  = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// rtl/multicycle_control_decode.sv - Moore state-to-datapath-controls table
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Every control defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = 2'b00;
                ctrl.pc_write  = 1'b1;
            end
            S_FETCH2: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
            end
            S_DECODE: begin
                // PC + (sign-extended offset << 2) lands in ALUOut for a later branch
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = 2'b00;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source  = 2'b10;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM: state register and sequencing
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;
    logic   illegal_raw;

    multicycle_control_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl_raw)
    );

    // State register; reset aborts any instruction in flight and parks in FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing; opCode is only looked at in DECODE and MEMADR
    always_comb begin
        state_d     = S_FETCH;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RTYPEWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            // final states of each instruction and the unused codes 14-15
            default:  state_d = S_FETCH;
        endcase
    end

    // FETCH is the reset state but must not drive the datapath while reset is held
    always_comb begin
        ctrl = reset ? ctrl_raw : '0;
    end

    assign illegal_op  = reset & illegal_raw;
    assign state       = state_q;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign instr_done  = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, reset1;
    logic [5:0] op0, op1;
    // {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst}
    logic [9:0] b0, b1;
    logic [1:0] pcs0, srcb0, aop0, pcs1, srcb1, aop1;
    logic [3:0] st0, st1;
    logic       done0, ill0, done1, ill1;
    logic [17:0] obs0, obs1;

    assign obs0 = {b0, pcs0, srcb0, aop0, done0, ill0};
    assign obs1 = {b1, pcs1, srcb1, aop1, done1, ill1};

    int n_checks = 0;
    int n_fail   = 0;
    int path_q[$];

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .opCode(op0),
        .PCWriteCond(b0[9]), .PCWrite(b0[8]), .IorD(b0[7]), .MemRead(b0[6]),
        .MemWrite(b0[5]), .MemtoReg(b0[4]), .IRWrite(b0[3]), .ALUSrcA(b0[2]),
        .RegWrite(b0[1]), .RegDst(b0[0]), .PCSource(pcs0), .ALUSrcB(srcb0),
        .ALUOp(aop0), .state(st0), .instr_done(done0), .illegal_op(ill0)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset1), .opCode(op1),
        .PCWriteCond(b1[9]), .PCWrite(b1[8]), .IorD(b1[7]), .MemRead(b1[6]),
        .MemWrite(b1[5]), .MemtoReg(b1[4]), .IRWrite(b1[3]), .ALUSrcA(b1[2]),
        .RegWrite(b1[1]), .RegDst(b1[0]), .PCSource(pcs1), .ALUSrcB(srcb1),
        .ALUOp(aop1), .state(st1), .instr_done(done1), .illegal_op(ill1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            6'b100011: return 6;
            6'b101011: return 5;
            6'b000000: return 5;
            6'b001000: return 5;
            6'b000100: return 4;
            6'b000010: return 4;
            default:   return 0;
        endcase
    endfunction

    // Expected controls per state, written from the control table
    function automatic logic [17:0] exp_ctrl(input int s, input bit ill);
        logic pwc, pw, iord, mr, mw, m2r, irw, asa, rw, rd, done;
        logic [1:0] pcs, sb, aop;
        pwc = 0; pw = 0; iord = 0; mr = 0; mw = 0; m2r = 0; irw = 0;
        asa = 0; rw = 0; rd = 0; done = 0; pcs = 0; sb = 0; aop = 0;
        case (s)
            0:  begin mr = 1; sb = 2'b01; pw = 1; end
            1:  begin mr = 1; irw = 1; end
            2:  begin sb = 2'b11; end
            3:  begin asa = 1; sb = 2'b10; end
            4:  begin iord = 1; mr = 1; end
            5:  begin iord = 1; mr = 1; m2r = 1; rw = 1; done = 1; end
            6:  begin iord = 1; mw = 1; done = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rd = 1; rw = 1; done = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; done = 1; end
            10: begin asa = 1; sb = 2'b10; end
            11: begin rw = 1; done = 1; end
            12: begin pcs = 2'b10; pw = 1; done = 1; end
            default: ;
        endcase
        return {pwc, pw, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, sb, aop, done, ill};
    endfunction

    // State path of one instruction starting at FETCH
    task automatic plan_path(input logic [5:0] op);
        path_q = {0, 1, 2};
        case (op)
            6'b100011: path_q = {path_q, 3, 4, 5};
            6'b101011: path_q = {path_q, 3, 6};
            6'b000000: path_q = {path_q, 7, 8};
            6'b000100: path_q = {path_q, 9};
            6'b001000: path_q = {path_q, 10, 11};
            6'b000010: path_q = {path_q, 12};
            default: ;
        endcase
    endtask

    // Runs up to max_n states of one instruction on dut0; entered and left just after a falling edge
    task automatic run_instr(input logic [5:0] op, input int max_n);
        int done_at;
        int s;
        done_at = 0;
        plan_path(op);
        for (int i = 0; i < path_q.size() && i < max_n; i++) begin
            s = path_q[i];
            op0 = (s == 2 || s == 3) ? op : 6'($urandom);
            #1;
            check("state", 32'(st0), s);
            check("ctrl", 32'(obs0), 32'(exp_ctrl(s, !legal(op) && s == 2)));
            check("memwrite_regwrite_excl", 32'(b0[5] & b0[1]), 0);
            check("pcwrite_pcwritecond_excl", 32'(b0[9] & b0[8]), 0);
            if (done0 === 1'b1 && done_at == 0) done_at = i + 1;
            @(negedge clk);
        end
        if (legal(op) && max_n >= path_q.size())
            check("latency", done_at, latency(op));
    endtask

    logic [5:0] rop;
    logic [5:0] dir_ops[7] = '{6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'b000000, 6'b001000};
    logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        reset0 = 1'b0;
        reset1 = 1'b0;
        op0    = 6'b100011;
        op1    = 6'b000000;

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'(obs0), 0);
            check("reset_state", 32'(st0), 0);
        end
        reset0 = 1'b1;

        foreach (dir_ops[i]) run_instr(dir_ops[i], 99);

        // abort an R-type in EXEC
        run_instr(6'b000000, 3);
        op0 = 6'($urandom);
        #1;
        check("abort_pre_state", 32'(st0), 7);
        reset0 = 1'b0;
        #1;
        check("abort_state", 32'(st0), 0);
        check("abort_outputs", 32'(obs0), 0);
        @(posedge clk);
        #1;
        check("abort_regwrite", 32'(b0[1]), 0);
        check("abort_state_hold", 32'(st0), 0);
        @(negedge clk);
        reset0 = 1'b1;
        run_instr(6'b000000, 99);

        for (int n = 0; n < 1000; n++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k == 6) begin
                rop = 6'($urandom);
                if (legal(rop)) rop = 6'b110011;
            end else begin
                rop = legal_ops[k];
            end
            run_instr(rop, 99);
        end

        // halting variant: illegal opcode parks the FSM
        @(negedge clk);
        check("halt_reset_outputs", 32'(obs1), 0);
        reset1 = 1'b1;
        op1    = 6'b111111;
        for (int i = 0; i < 13; i++) begin
            int s;
            s = (i < 3) ? i : 13;
            if (i >= 3) op1 = 6'($urandom);
            #1;
            check("halt_state", 32'(st1), s);
            check("halt_ctrl", 32'(obs1), 32'(exp_ctrl(s, s == 2)));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
